sinewave_table: RTL and testbench
=================================

SINEWAVE_TABLE -- requirements
Module: sinewave_table

Interface
REQ-001 Parameter SINE_WIDTH, default 7: output sample width in bits, two's complement, legal range 2..16.
REQ-002 Parameter LUT_WIDTH, default 8: address width in bits, giving 2^LUT_WIDTH samples per period, legal range 3..12.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port arst, input, 1 bit: reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-005 Port address, input, LUT_WIDTH bits, unsigned: phase index, where 0 is phase 0 and 2^LUT_WIDTH-1 is just below 2*pi.
REQ-006 Port value, output, signed SINE_WIDTH bits, registered: sine sample for the registered address.

Function
REQ-007 Amplitude A SHALL be 2^(SINE_WIDTH-1)-1 (63 at defaults); -2^(SINE_WIDTH-1) SHALL never be output.
REQ-008 Table entry for address k SHALL be round(A*sin(2*pi*k/2^LUT_WIDTH)), rounding half away from zero.
REQ-009 Entries SHALL be exactly odd-symmetric: entry(k) = -entry(2^LUT_WIDTH-k) for k in 1..2^LUT_WIDTH-1; entry(0) = entry(2^(LUT_WIDTH-1)) = 0.
REQ-010 Quarter-period entries SHALL be exact: entry(2^(LUT_WIDTH-2)) = +A and entry(3*2^(LUT_WIDTH-2)) = -A.
REQ-011 Table contents SHALL be constant, computed at elaboration or hard-coded, with no runtime writes.
REQ-012 Latency SHALL be one clk cycle: address sampled at edge n appears on value after edge n and holds until the next edge.
REQ-013 A new address SHALL be accepted every cycle, with no handshake and no stall.
REQ-014 Address wrap-around SHALL be continuous: address 2^LUT_WIDTH-1 followed by 0 gives consecutive samples of one period with no discontinuity beyond normal quantisation.
REQ-015 The block SHALL contain no arithmetic on address other than the symmetry folding of REQ-021; phase offsets (e.g. +2^(LUT_WIDTH-2) for cosine) are the instantiator's job.
REQ-016 Output SHALL be a pure function of the last sampled address, independent of history.

Reset
REQ-017 While arst is high at a rising clk edge, value SHALL become 0 on that edge.
REQ-018 On the first edge with arst low, value SHALL take the table entry for the address present at that edge.
REQ-019 Asserting arst mid-stream SHALL override the address lookup in that cycle; no other state exists.

Configuration
REQ-020 Macro SINEWAVE_TABLE_QUARTER_WAVE_EN SHALL select the table storage scheme.
REQ-021 With the macro defined: store only entries 0..2^(LUT_WIDTH-2) (2^(LUT_WIDTH-2)+1 words, unsigned magnitudes). Fold the address using its two MSBs: mirror the index in quadrants 1 and 3, negate the result in quadrants 2 and 3.
REQ-022 Without the macro: store all 2^LUT_WIDTH signed entries and index directly.
REQ-023 Both builds SHALL produce bit-identical value sequences and the same one-cycle latency for every address and reset sequence.

Verification (defaults SINE_WIDTH=7, LUT_WIDTH=8; run in both macro builds)
REQ-024 Reset check: arst=1 for 3 cycles with address=64 -> value=0 throughout; release arst -> value=63 one cycle later.
REQ-025 Key points: addresses 0, 64, 128, 192 -> values 0, 63, 0, -63, each one cycle after its address.
REQ-026 Interior points: addresses 1, 16, 32, 96, 160, 255 -> values 2, 24, 45, 45, -45, -2.
REQ-027 Full sweep: address 0..255, one per cycle, wrapping to 0 -> every value matches the REQ-008 formula, odd symmetry holds, and |value| <= 63.
REQ-028 Cosine pairing: two instances, the second fed (k+64) mod 256 -> the second's output equals the first's output for k+64, e.g. k=0 gives 0 and 63.
REQ-029 Mid-stream reset: during the sweep assert arst for 1 cycle at address 40 -> value 0 for that cycle, then the lookup resumes with no other disturbance.

Source files
------------

// File: rtl/sinewave_table.sv
// Registered sine lookup: one sample per cycle, one-cycle latency, table built at elaboration.
// Define SINEWAVE_TABLE_QUARTER_WAVE_EN to store a quarter wave and fold the address instead of a full period.
module sinewave_table #(
   parameter int SINE_WIDTH = 7,
   parameter int LUT_WIDTH  = 8
) (
   input  logic                         clk,
   input  logic                         arst,
   input  logic [LUT_WIDTH-1:0]         address,
   output logic signed [SINE_WIDTH-1:0] value
);

   localparam int  AMP     = (1 << (SINE_WIDTH - 1)) - 1;
   localparam int  QTR     = 1 << (LUT_WIDTH - 2);
   localparam real HALF_PI = 1.5707963267948966;

   // Taylor series; x stays within [0, pi/2] so 12 terms are far below one LSB of error.
   function automatic real sin_q(input real x);
      real term;
      real sum;
      term = x;
      sum  = x;
      for (int n = 1; n <= 12; n++) begin
         term = -term * x * x / real'((2 * n) * (2 * n + 1));
         sum  = sum + term;
      end
      return sum;
   endfunction

   // Magnitude is non-negative, so adding one half and truncating rounds half away from zero.
   function automatic int quarter_mag(input int k);
      real x;
      x = HALF_PI * real'(k) / real'(QTR);
      return $rtoi(real'(AMP) * sin_q(x) + 0.5);
   endfunction

   logic signed [SINE_WIDTH-1:0] lookup_s;
   logic signed [SINE_WIDTH-1:0] value_d;
   logic signed [SINE_WIDTH-1:0] value_q;

`ifdef SINEWAVE_TABLE_QUARTER_WAVE_EN
   localparam int QW = SINE_WIDTH - 1;
   localparam logic [LUT_WIDTH-2:0] QTR_V = (LUT_WIDTH - 1)'(QTR);

   function automatic logic [(QTR+1)*QW-1:0] build_quarter();
      logic [(QTR+1)*QW-1:0] t;
      t = '0;
      for (int k = 0; k <= QTR; k++) begin
         t[k*QW +: QW] = QW'(quarter_mag(k));
      end
      return t;
   endfunction

   localparam logic [(QTR+1)*QW-1:0] QROM = build_quarter();

   logic [1:0]           quad_s;
   logic [LUT_WIDTH-3:0] idx_s;
   logic [LUT_WIDTH-2:0] fold_s;
   logic [QW-1:0]        mag_s;
   logic [SINE_WIDTH-1:0] ext_s;

   assign quad_s = address[LUT_WIDTH-1 -: 2];
   assign idx_s  = address[LUT_WIDTH-3:0];

   // Fold the address onto the first quadrant and restore the sign from the upper half.
   always_comb begin
      fold_s   = {1'b0, idx_s};
      mag_s    = '0;
      ext_s    = '0;
      lookup_s = '0;
      if (quad_s[0]) begin
         fold_s = QTR_V - {1'b0, idx_s};
      end else begin
         fold_s = {1'b0, idx_s};
      end
      mag_s = QROM[int'(fold_s)*QW +: QW];
      ext_s = {1'b0, mag_s};
      if (quad_s[1]) begin
         lookup_s = {SINE_WIDTH{1'b0}} - ext_s;
      end else begin
         lookup_s = ext_s;
      end
   end
`else
   localparam int DEPTH = 1 << LUT_WIDTH;

   // Full period derived from the quarter magnitudes so odd symmetry is exact by construction.
   function automatic logic [DEPTH*SINE_WIDTH-1:0] build_full();
      logic [DEPTH*SINE_WIDTH-1:0] t;
      int q;
      int i;
      int m;
      t = '0;
      for (int k = 0; k < DEPTH; k++) begin
         q = k / QTR;
         i = k % QTR;
         m = ((q == 1) || (q == 3)) ? quarter_mag(QTR - i) : quarter_mag(i);
         t[k*SINE_WIDTH +: SINE_WIDTH] = (q >= 2) ? SINE_WIDTH'(-m) : SINE_WIDTH'(m);
      end
      return t;
   endfunction

   localparam logic [DEPTH*SINE_WIDTH-1:0] FROM = build_full();

   // Direct lookup into the full-period table.
   always_comb begin
      lookup_s = FROM[int'(address)*SINE_WIDTH +: SINE_WIDTH];
   end
`endif

   // Reset overrides the lookup for the cycle it is sampled.
   always_comb begin
      if (arst) begin
         value_d = {SINE_WIDTH{1'b0}};
      end else begin
         value_d = lookup_s;
      end
   end

   // Output sample register.
   always_ff @(posedge clk) begin
      value_q <= value_d;
   end

   assign value = value_q;

endmodule

// File: tb/tb_sinewave_table.sv
// Directed bench for sinewave_table at default parameters: reset, key/interior points, sweep, cosine pairing.
module tb_sinewave_table;

   logic              clk;
   logic              arst;
   logic [7:0]        address;
   logic [7:0]        address_b;
   logic signed [6:0] value_a;
   logic signed [6:0] value_b;

   int checks;
   int errors;
   int obs [256];

   sinewave_table #(.SINE_WIDTH(7), .LUT_WIDTH(8)) dut_a (
      .clk(clk), .arst(arst), .address(address), .value(value_a)
   );

   sinewave_table #(.SINE_WIDTH(7), .LUT_WIDTH(8)) dut_b (
      .clk(clk), .arst(arst), .address(address_b), .value(value_b)
   );

   assign address_b = address + 8'd64;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model(input int k);
      real r;
      r = 63.0 * $sin(2.0 * 3.14159265358979323846 * real'(k) / 256.0);
      if (r >= 0.0) return $rtoi(r + 0.5);
      else return -$rtoi(-r + 0.5);
   endfunction

   task automatic check(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic step(input int a, input logic r);
      address = 8'(a);
      arst    = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int key_a [4];
      int key_v [4];
      int in_a  [6];
      int in_v  [6];
      int mag;
      checks  = 0;
      errors  = 0;
      key_a   = '{0, 64, 128, 192};
      key_v   = '{0, 63, 0, -63};
      in_a    = '{1, 16, 32, 96, 160, 255};
      in_v    = '{2, 24, 45, 45, -45, -2};
      address = 8'd64;
      arst    = 1'b1;

      for (int c = 0; c < 3; c++) begin
         step(64, 1'b1);
         check("reset_hold", int'(value_a), 0);
      end
      step(64, 1'b0);
      check("reset_release", int'(value_a), 63);

      for (int i = 0; i < 4; i++) begin
         step(key_a[i], 1'b0);
         check($sformatf("key_%0d", key_a[i]), int'(value_a), key_v[i]);
      end
      for (int i = 0; i < 6; i++) begin
         step(in_a[i], 1'b0);
         check($sformatf("interior_%0d", in_a[i]), int'(value_a), in_v[i]);
      end

      for (int k = 0; k <= 256; k++) begin
         step(k % 256, 1'b0);
         check($sformatf("sweep_%0d", k), int'(value_a), model(k % 256));
         check($sformatf("cosine_%0d", k), int'(value_b), model((k + 64) % 256));
         mag = (value_a < 0) ? -int'(value_a) : int'(value_a);
         check($sformatf("bound_%0d", k), int'(mag <= 63), 1);
         if (k < 256) obs[k] = int'(value_a);
      end
      check("sym_zero_0", obs[0], 0);
      check("sym_zero_128", obs[128], 0);
      for (int k = 1; k < 256; k++) begin
         check($sformatf("odd_sym_%0d", k), obs[k], -obs[256 - k]);
      end

      for (int k = 30; k <= 50; k++) begin
         step(k, (k == 40) ? 1'b1 : 1'b0);
         check($sformatf("midreset_%0d", k), int'(value_a), (k == 40) ? 0 : model(k));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
